// File: rtl/gb_pkg.sv
// Shared system-bus types, timer register map and timer state encoding.
package gb_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [7:0]  data_t;

   typedef struct packed {
      logic enable;
      logic write;
      logic commit;
   } bus_ctl_t;

   localparam addr_t ADDR_DIV  = 16'hFF04;
   localparam addr_t ADDR_TIMA = 16'hFF05;
   localparam addr_t ADDR_TMA  = 16'hFF06;
   localparam addr_t ADDR_TAC  = 16'hFF07;

   typedef enum logic [1:0] {
      RegDiv  = 2'd0,
      RegTima = 2'd1,
      RegTma  = 2'd2,
      RegTac  = 2'd3
   } timer_reg_e;

   typedef enum logic [1:0] {
      IdleState,
      DelayState,
      ReloadState
   } timer_state_e;

endpackage

// File: rtl/timer_if.sv
// System-bus responder port bundle: the CPU is master, I/O blocks are slaves.
interface timer_if;
   import gb_pkg::*;

   addr_t mem_addr;
   logic  mem_enable;
   logic  mem_write;
   logic  mem_commit;
   data_t mem_data_in;
   data_t mem_data_out;
   logic  mem_select;

   modport master (
      output mem_addr, mem_enable, mem_write, mem_commit, mem_data_in,
      input  mem_data_out, mem_select
   );

   modport slave (
      input  mem_addr, mem_enable, mem_write, mem_commit, mem_data_in,
      output mem_data_out, mem_select
   );

endinterface

// File: rtl/timer_tick.sv
// TAC divider-bit mux and falling-edge detector producing the TIMA tick.
module timer_tick (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  tac_i,
   input  logic [15:0] div_i,
   output logic        tick_o
);

   logic div_bit;
   logic s;
   logic s_q;

   always_comb begin
      div_bit = 1'b0;
      case (tac_i[1:0])
         2'b00:   div_bit = div_i[9];
         2'b01:   div_bit = div_i[3];
         2'b10:   div_bit = div_i[5];
         default: div_bit = div_i[7];
      endcase
   end

   // Disabling TAC or clearing DIV while the bit is high also ticks.
   assign s      = tac_i[2] & div_bit;
   assign tick_o = s_q & ~s;

   always_ff @(posedge clk) begin
      if (reset) s_q <= 1'b0;
      else       s_q <= s;
   end

endmodule

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer on the system bus with delayed TIMA reload and irq.
module timer
   import gb_pkg::*;
#(
   parameter addr_t BASE_ADDR = ADDR_DIV
) (
   input  logic    clk,
   input  logic    reset,
   timer_if.slave  bus,
   output logic    irq_timer
);

   logic [15:0]  div_q, div_d;
   data_t        tima_q, tima_d;
   data_t        tma_q, tma_d;
   logic [2:0]   tac_q, tac_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         irq_q, irq_d;
   timer_state_e state_q, state_d;

   addr_t      off;
   timer_reg_e reg_sel;
   logic       we;
   logic       we_div, we_tima, we_tma, we_tac;
   logic       tick;

   assign off            = bus.mem_addr - BASE_ADDR;
   assign reg_sel        = timer_reg_e'(off[1:0]);
   assign bus.mem_select = bus.mem_enable & (off[15:2] == 14'd0);

   assign we      = bus.mem_select & bus.mem_write & bus.mem_commit;
   assign we_div  = we & (reg_sel == RegDiv);
   assign we_tima = we & (reg_sel == RegTima);
   assign we_tma  = we & (reg_sel == RegTma);
   assign we_tac  = we & (reg_sel == RegTac);

   always_comb begin
      bus.mem_data_out = 8'hFF;
      if (bus.mem_select) begin
         case (reg_sel)
            RegDiv:  bus.mem_data_out = div_q[15:8];
            RegTima: bus.mem_data_out = tima_q;
            RegTma:  bus.mem_data_out = tma_q;
            default: bus.mem_data_out = {5'b11111, tac_q};
         endcase
      end
   end

   timer_tick u_tick (
      .clk    (clk),
      .reset  (reset),
      .tac_i  (tac_q),
      .div_i  (div_q),
      .tick_o (tick)
   );

   assign div_d = we_div ? 16'd0 : div_q + 16'd1;
   assign tma_d = we_tma ? bus.mem_data_in : tma_q;
   assign tac_d = we_tac ? bus.mem_data_in[2:0] : tac_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tima_d  = tima_q;
      irq_d   = 1'b0;
      case (state_q)
         IdleState: begin
            if (we_tima) begin
               tima_d = bus.mem_data_in;
            end else if (tick) begin
               if (tima_q == 8'hFF) begin
                  tima_d  = 8'h00;
                  state_d = DelayState;
                  cnt_d   = 2'd3;
               end else begin
                  tima_d = tima_q + 8'd1;
               end
            end
         end
         DelayState: begin
            if (we_tima) begin
               tima_d  = bus.mem_data_in;
               state_d = IdleState;
            end else if (cnt_q == 2'd0) begin
               // tma_d lets a same-edge TMA write reach TIMA.
               tima_d  = tma_d;
               irq_d   = 1'b1;
               state_d = ReloadState;
               cnt_d   = 2'd3;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ReloadState: begin
            if (we_tma) tima_d = bus.mem_data_in;
            if (cnt_q == 2'd0) state_d = IdleState;
            else               cnt_d   = cnt_q - 2'd1;
         end
         default: state_d = IdleState;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= 16'd0;
         tima_q  <= 8'h00;
         tma_q   <= 8'h00;
         tac_q   <= 3'd0;
         cnt_q   <= 2'd0;
         irq_q   <= 1'b0;
         state_q <= IdleState;
      end else begin
         div_q   <= div_d;
         tima_q  <= tima_d;
         tma_q   <= tma_d;
         tac_q   <= tac_d;
         cnt_q   <= cnt_d;
         irq_q   <= irq_d;
         state_q <= state_d;
      end
   end

   assign irq_timer = irq_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for the bus timer: DIV, TIMA counting, overflow reload, irq.
module tb_timer;
   import gb_pkg::*;

   logic clk;
   logic reset;
   logic irq;
   int   total;
   int   bad;
   logic found;
   logic seen;
   data_t d;

   timer_if bus ();

   timer #(.BASE_ADDR(16'hFF04)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .irq_timer (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wr(input addr_t a, input data_t v);
      bus.mem_addr    = a;
      bus.mem_data_in = v;
      bus.mem_enable  = 1'b1;
      bus.mem_write   = 1'b1;
      bus.mem_commit  = 1'b1;
      @(negedge clk);
      bus.mem_enable  = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_commit  = 1'b0;
   endtask

   task automatic rd(input addr_t a, output data_t v);
      bus.mem_addr   = a;
      bus.mem_enable = 1'b1;
      bus.mem_write  = 1'b0;
      bus.mem_commit = 1'b0;
      #1;
      v = bus.mem_data_out;
   endtask

   task automatic rst();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Returns at the first negedge after the overflow edge.
   task automatic ovf_setup(output logic ok);
      data_t v;
      ok = 1'b0;
      rst();
      wr(ADDR_TMA, 8'hAB);
      wr(ADDR_TIMA, 8'hFF);
      wr(ADDR_TAC, 8'h05);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         rd(ADDR_TIMA, v);
         if (v == 8'h00) ok = 1'b1;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.mem_addr    = 16'h0000;
      bus.mem_enable  = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_commit  = 1'b0;
      bus.mem_data_in = 8'h00;

      repeat (2) @(negedge clk);
      rd(ADDR_DIV, d);  chk("rst_div", d, 8'h00);
      rd(ADDR_TIMA, d); chk("rst_tima", d, 8'h00);
      rd(ADDR_TMA, d);  chk("rst_tma", d, 8'h00);
      rd(ADDR_TAC, d);  chk("rst_tac", d, 8'hF8);
      chk("rst_irq", irq, 1'b0);
      reset = 1'b0;

      repeat (255) @(negedge clk);
      rd(ADDR_DIV, d); chk("div_255", d, 8'h00);
      @(negedge clk);
      rd(ADDR_DIV, d); chk("div_256", d, 8'h01);
      wr(ADDR_DIV, 8'h5A);
      rd(ADDR_DIV, d); chk("div_clr", d, 8'h00);

      wr(ADDR_DIV, 8'h00);
      wr(ADDR_TAC, 8'h05);
      repeat (169) @(negedge clk);
      rd(ADDR_TIMA, d); chk("tima_170", d, 8'h0A);

      ovf_setup(found);
      chk("ovf_found", found, 1'b1);
      chk("ovf_irq0", irq, 1'b0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         rd(ADDR_TIMA, d);
         chk("ovf_delay_tima", d, 8'h00);
         chk("ovf_delay_irq", irq, 1'b0);
      end
      @(negedge clk);
      rd(ADDR_TIMA, d); chk("ovf_reload", d, 8'hAB);
      chk("ovf_irq1", irq, 1'b1);
      @(negedge clk);
      chk("ovf_irq_end", irq, 1'b0);

      ovf_setup(found);
      chk("cancel_found", found, 1'b1);
      wr(ADDR_TIMA, 8'h42);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (irq) seen = 1'b1;
         @(negedge clk);
      end
      chk("cancel_irq", seen, 1'b0);
      rd(ADDR_TIMA, d); chk("cancel_tima", d, 8'h42);

      ovf_setup(found);
      chk("rl_found", found, 1'b1);
      repeat (4) @(negedge clk);
      wr(ADDR_TIMA, 8'h55);
      rd(ADDR_TIMA, d); chk("rl_tima_ign", d, 8'hAB);
      wr(ADDR_TMA, 8'h11);
      rd(ADDR_TIMA, d); chk("rl_tma_tima", d, 8'h11);
      rd(ADDR_TMA, d);  chk("rl_tma", d, 8'h11);

      ovf_setup(found);
      chk("edge_found", found, 1'b1);
      repeat (3) @(negedge clk);
      wr(ADDR_TMA, 8'h77);
      rd(ADDR_TIMA, d); chk("edge_tma_tima", d, 8'h77);
      chk("edge_irq", irq, 1'b1);

      ovf_setup(found);
      chk("rstd_found", found, 1'b1);
      rst();
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (irq) seen = 1'b1;
         @(negedge clk);
      end
      chk("rstd_irq", seen, 1'b0);
      rd(ADDR_TIMA, d); chk("rstd_tima", d, 8'h00);

      rst();
      wr(ADDR_TAC, 8'h04);
      repeat (600) @(negedge clk);
      rd(ADDR_TIMA, d); chk("gl_pre", d, 8'h00);
      wr(ADDR_DIV, 8'hFF);
      @(negedge clk);
      rd(ADDR_TIMA, d); chk("gl_div", d, 8'h01);
      repeat (600) @(negedge clk);
      wr(ADDR_TAC, 8'h00);
      @(negedge clk);
      rd(ADDR_TIMA, d); chk("gl_tac", d, 8'h02);

      rst();
      wr(ADDR_TAC, 8'h05);
      rd(16'hFF07, d); chk("tac_rd", d, 8'hFD);
      chk("tac_sel", bus.mem_select, 1'b1);
      rd(16'hFF08, d); chk("hi_data", d, 8'hFF);
      chk("hi_sel", bus.mem_select, 1'b0);
      rd(16'hFF03, d); chk("lo_data", d, 8'hFF);
      chk("lo_sel", bus.mem_select, 1'b0);
      bus.mem_addr   = ADDR_TMA;
      bus.mem_enable = 1'b0;
      #1;
      chk("dis_sel", bus.mem_select, 1'b0);
      chk("dis_data", bus.mem_data_out, 8'hFF);

      @(negedge clk);
      bus.mem_addr    = ADDR_TMA;
      bus.mem_data_in = 8'h99;
      bus.mem_enable  = 1'b1;
      bus.mem_write   = 1'b1;
      bus.mem_commit  = 1'b0;
      @(negedge clk);
      bus.mem_write   = 1'b0;
      rd(ADDR_TMA, d); chk("nocommit", d, 8'h00);
      bus.mem_addr    = 16'hFF08;
      bus.mem_write   = 1'b1;
      bus.mem_commit  = 1'b1;
      @(negedge clk);
      bus.mem_write   = 1'b0;
      bus.mem_commit  = 1'b0;
      rd(ADDR_TMA, d); chk("nosel_tma", d, 8'h00);
      rd(ADDR_TIMA, d); chk("nosel_tima", d, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
